// File: rtl/fpga_ram_bank_arbiter.sv
// ---------------------------------------------------------------------------
// fpga_ram_bank_arbiter
//
// Round-robin arbiter sharing one single-port block-RAM bank of the L2
// interleaved region among N_PORTS TCDM-style requesters. At most one access
// is granted per cycle. The granted port's payload is driven onto the bank
// pins, and a small (valid, owner) pipeline tracks the BRAM read latency so
// each response pulses rvalid_o for the port that issued it.
//
// Parameters:
//   N_PORTS     number of requesters (2..8)
//   ADDR_WIDTH  bank word-address width
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i / gnt_o                per-port request / one-hot-or-zero grant
//   addr_i, wen_i, be_i, wdata_i per-port payload (wen active-low)
//   rvalid_o, rdata_o            per-port response valid, broadcast read data
//   mem_csn_o, mem_wen_o,        bank chip select (active-low), write enable
//   mem_be_o, mem_addr_o,        (active-low), byte enables, address,
//   mem_wdata_o, mem_rdata_i     write data, read data
//
// Configuration macro:
//   FPGA_RAM_ARB_RDATA_REG_EN  BRAM output register enabled; bank data and
//                              rvalid_o arrive two cycles after the access
//                              instead of one.
// ---------------------------------------------------------------------------
module fpga_ram_bank_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_PORTS-1:0]             req_i,
    output logic [N_PORTS-1:0]             gnt_o,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [N_PORTS-1:0]             wen_i,
    input  logic [N_PORTS*4-1:0]           be_i,
    input  logic [N_PORTS*32-1:0]          wdata_i,
    output logic [N_PORTS-1:0]             rvalid_o,
    output logic [31:0]                    rdata_o,
    output logic                           mem_csn_o,
    output logic                           mem_wen_o,
    output logic [3:0]                     mem_be_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [31:0]                    mem_wdata_o,
    input  logic [31:0]                    mem_rdata_i
);

    localparam int RR_W = $clog2(N_PORTS);

    // (base + k) mod N_PORTS; base < N_PORTS and k <= N_PORTS, so a single
    // conditional subtract is enough.
    function automatic logic [RR_W-1:0] wrap_add(input logic [RR_W-1:0] base,
                                                 input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_PORTS) begin
            s = s - N_PORTS;
        end
        return s[RR_W-1:0];
    endfunction

    logic [RR_W-1:0] rr_q;
    logic [RR_W-1:0] rr_d;
    logic            gnt_any;
    logic [RR_W-1:0] gnt_idx;
    logic [RR_W-1:0] cand;

    // ---- stage p0: arbitration and bank drive (same cycle as request) ----
    // Search starts at the round-robin pointer and wraps; the first asserted
    // request wins. Reset forces the grant off so the bank stays idle.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = wrap_add(rr_q, k);
            if (!gnt_any && req_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst_i) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (gnt_any) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    // Byte enables pass through on reads as well; the bank wrapper masks
    // them with wen.
    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt_any) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = wen_i[gnt_idx];
            mem_be_o    = be_i[int'(gnt_idx)*4 +: 4];
            mem_addr_o  = addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o = wdata_i[int'(gnt_idx)*32 +: 32];
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_comb begin
        rr_d = rr_q;
        if (gnt_any) begin
            rr_d = wrap_add(gnt_idx, 1);
        end
    end

    // ---- stage p1: first response stage (bank access just completed) ----
    logic            rsp_vld_p1_q;
    logic            rsp_vld_p1_d;
    logic [RR_W-1:0] rsp_own_p1_q;
    logic [RR_W-1:0] rsp_own_p1_d;

    always_comb begin
        rsp_vld_p1_d = gnt_any;
        rsp_own_p1_d = gnt_idx;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            rsp_vld_p1_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            rsp_vld_p1_q <= rsp_vld_p1_d;
        end
    end

    // Owner index is only meaningful alongside its valid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        rsp_own_p1_q <= rsp_own_p1_d;
    end

    logic            rsp_vld_out;
    logic [RR_W-1:0] rsp_own_out;

`ifdef FPGA_RAM_ARB_RDATA_REG_EN
    // ---- stage p2: extra stage matching the BRAM output register ----
    logic            rsp_vld_p2_q;
    logic            rsp_vld_p2_d;
    logic [RR_W-1:0] rsp_own_p2_q;
    logic [RR_W-1:0] rsp_own_p2_d;

    always_comb begin
        rsp_vld_p2_d = rsp_vld_p1_q;
        rsp_own_p2_d = rsp_own_p1_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_vld_p2_q <= 1'b0;
        end else begin
            rsp_vld_p2_q <= rsp_vld_p2_d;
        end
    end

    always_ff @(posedge clk_i) begin
        rsp_own_p2_q <= rsp_own_p2_d;
    end

    assign rsp_vld_out = rsp_vld_p2_q;
    assign rsp_own_out = rsp_own_p2_q;
`else
    assign rsp_vld_out = rsp_vld_p1_q;
    assign rsp_own_out = rsp_own_p1_q;
`endif

    // ---- response output: steer the end-of-pipeline valid to its owner ----
    always_comb begin
        rvalid_o = '0;
        if (rsp_vld_out) begin
            rvalid_o[rsp_own_out] = 1'b1;
        end
    end

    // Bank data is already aligned with the end of the pipeline; it is only
    // forced to zero while reset is held.
    assign rdata_o = rst_i ? 32'h0 : mem_rdata_i;

endmodule

// File: tb/tb_fpga_ram_bank_arbiter.sv
module tb_fpga_ram_bank_arbiter;
    localparam int NP = 4;
    localparam int AW = 12;
`ifdef FPGA_RAM_ARB_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_i;
    logic [NP-1:0]     gnt_o;
    logic [NP*AW-1:0]  addr_i;
    logic [NP-1:0]     wen_i;
    logic [NP*4-1:0]   be_i;
    logic [NP*32-1:0]  wdata_i;
    logic [NP-1:0]     rvalid_o;
    logic [31:0]       rdata_o;
    logic              mem_csn_o;
    logic              mem_wen_o;
    logic [3:0]        mem_be_o;
    logic [AW-1:0]     mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    logic          p_wen[NP];
    logic [AW-1:0] p_addr[NP];
    logic [3:0]    p_be[NP];
    logic [31:0]   p_wdata[NP];

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign wen_i[g]             = p_wen[g];
        assign addr_i[g*AW +: AW]   = p_addr[g];
        assign be_i[g*4 +: 4]       = p_be[g];
        assign wdata_i[g*32 +: 32]  = p_wdata[g];
    end

    always #5 clk = ~clk;

    fpga_ram_bank_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .wen_i(wen_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_csn_o(mem_csn_o), .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Behavioural BRAM bank driven by the arbiter's mem_* pins.
    logic [31:0] bank[1<<AW];
    logic [31:0] rd1;
    logic [31:0] rd2;
    always @(posedge clk) begin
        if (!mem_csn_o) begin
            if (!mem_wen_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) bank[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                rd1 <= bank[mem_addr_o];
            end
        end
        rd2 <= rd1;
    end
`ifdef FPGA_RAM_ARB_RDATA_REG_EN
    assign mem_rdata_i = rd2;
`else
    assign mem_rdata_i = rd1;
`endif

    // Reference memory and scoreboard of expected responses.
    logic [31:0] ref_mem[1<<AW];
    typedef struct {
        int          port;
        bit          is_rd;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int model_rr = 0;
    int rv_cnt[NP];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NP-1:0] onehot(input int i);
        logic [NP-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int exp_grant(input logic [NP-1:0] r, input int rr);
        for (int k = 0; k < NP; k++) begin
            int i;
            i = (rr + k) % NP;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        p_wen[p] = w; p_addr[p] = a; p_be[p] = be; p_wdata[p] = d;
    endtask

    task automatic sb_push(input int p);
        exp_t e;
        e.port  = p;
        e.is_rd = p_wen[p];
        e.due   = cyc + LAT;
        e.data  = '0;
        if (!p_wen[p]) begin
            for (int b = 0; b < 4; b++)
                if (p_be[p][b]) ref_mem[p_addr[p]][8*b +: 8] = p_wdata[p][8*b +: 8];
        end else begin
            e.data = ref_mem[p_addr[p]];
        end
        sb.push_back(e);
    endtask

    // Drive a request vector and stop at the sampling edge of that cycle.
    task automatic cycle_drive(input logic [NP-1:0] r, output int e);
        req_i = r;
        @(negedge clk);
        e = exp_grant(r, model_rr);
    endtask

    task automatic cycle_finish(input int e);
        if (e >= 0) begin
            sb_push(e);
            model_rr = (e + 1) % NP;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_i = '0;
        repeat (LAT + 2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req_i = '0;
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_rr = 0;
    endtask

    // Response checker: pops the scoreboard when an entry falls due.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++)
            if (rvalid_o[p] === 1'b1) rv_cnt[p]++;
        if (rst) begin
            n_chk++;
            if (rvalid_o !== '0 || rdata_o !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rsp: rvalid=%b rdata=%h, required 0/0", rvalid_o, rdata_o);
            end
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            n_chk++;
            if (rvalid_o !== onehot(sb[0].port)) begin
                n_fail++;
                $display("FAIL rvalid: cycle %0d got %b required %b", cyc, rvalid_o, onehot(sb[0].port));
            end
            if (sb[0].is_rd) begin
                n_chk++;
                if (rdata_o !== sb[0].data) begin
                    n_fail++;
                    $display("FAIL rdata: cycle %0d port %0d got %h required %h", cyc, sb[0].port, rdata_o, sb[0].data);
                end
            end
            void'(sb.pop_front());
        end else begin
            n_chk++;
            if (rvalid_o !== '0) begin
                n_fail++;
                $display("FAIL rvalid_idle: cycle %0d got %b required 0", cyc, rvalid_o);
            end
        end
    end

    task automatic test_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(p), 4'hF, 32'h1234_0000 + p);
        req_i = '1;
        @(negedge clk);
        n_chk++;
        if (gnt_o !== '0 || mem_csn_o !== 1'b1 || mem_wen_o !== 1'b1 || mem_be_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_drive: gnt=%b csn=%b wen=%b be=%h, required 0/1/1/0", gnt_o, mem_csn_o, mem_wen_o, mem_be_o);
        end
        @(posedge clk);
        #1;
        req_i = '0;
        rst = 1'b0;
        model_rr = 0;
        @(negedge clk);
        n_chk++;
        if (dut.rr_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_rr: got %0d required 0", dut.rr_q);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        int e;
        set_port(0, 1'b0, 12'h010, 4'hF, 32'hDEAD_BEEF);
        cycle_drive(4'b0001, e);
        n_chk++;
        if (gnt_o !== 4'b0001 || mem_csn_o !== 1'b0 || mem_wen_o !== 1'b0 ||
            mem_addr_o !== 12'h010 || mem_wdata_o !== 32'hDEAD_BEEF || mem_be_o !== 4'hF) begin
            n_fail++;
            $display("FAIL single_wr: gnt=%b csn=%b wen=%b addr=%h wdata=%h be=%h", gnt_o, mem_csn_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_be_o);
        end
        cycle_finish(e);
        set_port(1, 1'b1, 12'h010, 4'hF, 32'h0);
        cycle_drive(4'b0010, e);
        n_chk++;
        if (gnt_o !== 4'b0010 || mem_wen_o !== 1'b1 || mem_addr_o !== 12'h010) begin
            n_fail++;
            $display("FAIL single_rd: gnt=%b wen=%b addr=%h, required 0010/1/010", gnt_o, mem_wen_o, mem_addr_o);
        end
        cycle_finish(e);
        req_i = '0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_chk++;
        if (rvalid_o !== 4'b0010 || rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_rsp: rvalid=%b rdata=%h, required 0010/deadbeef", rvalid_o, rdata_o);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_byte_enables();
        int e;
        set_port(0, 1'b0, 12'h020, 4'b0101, 32'hAABB_CCDD);
        cycle_drive(4'b0001, e);
        n_chk++;
        if (gnt_o !== onehot(e) || mem_be_o !== 4'b0101) begin
            n_fail++;
            $display("FAIL be_wr: gnt=%b be=%b, required %b/0101", gnt_o, mem_be_o, onehot(e));
        end
        cycle_finish(e);
        set_port(0, 1'b1, 12'h020, 4'hF, 32'h0);
        cycle_drive(4'b0001, e);
        cycle_finish(e);
        req_i = '0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_chk++;
        if (rvalid_o !== 4'b0001 || rdata_o !== 32'h00BB_00DD) begin
            n_fail++;
            $display("FAIL be_rsp: rvalid=%b rdata=%h, required 0001/00bb00dd", rvalid_o, rdata_o);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_fairness();
        int e;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            set_port(p, 1'b1, 12'h100 + AW'(p), 4'hF, 32'h0);
            rv_cnt[p] = 0;
        end
        for (int i = 0; i < 8; i++) begin
            cycle_drive('1, e);
            n_chk++;
            if (gnt_o !== onehot(i % NP)) begin
                n_fail++;
                $display("FAIL fair_gnt: step %0d got %b required %b", i, gnt_o, onehot(i % NP));
            end
            cycle_finish(e);
        end
        drain();
        for (int p = 0; p < NP; p++) begin
            n_chk++;
            if (rv_cnt[p] !== 2) begin
                n_fail++;
                $display("FAIL fair_rvalid_count: port %0d got %0d required 2", p, rv_cnt[p]);
            end
        end
    endtask

    task automatic test_idle();
        int e;
        set_port(2, 1'b1, 12'h030, 4'hF, 32'h0);
        cycle_drive(4'b0100, e);
        cycle_finish(e);
        drain();
        for (int i = 0; i < 5; i++) begin
            cycle_drive('0, e);
            n_chk++;
            if (gnt_o !== '0 || mem_csn_o !== 1'b1 || dut.rr_q !== 2'd3) begin
                n_fail++;
                $display("FAIL idle: gnt=%b csn=%b rr=%0d, required 0/1/3", gnt_o, mem_csn_o, dut.rr_q);
            end
            cycle_finish(e);
        end
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 12'h030, 4'hF, 32'h0);
        cycle_drive('1, e);
        n_chk++;
        if (gnt_o !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_resume: got %b required 1000", gnt_o);
        end
        cycle_finish(e);
        drain();
    endtask

    task automatic test_back_to_back();
        int e;
        logic [NP-1:0] pend;
        pend = '0;
        for (int i = 0; i < 60; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && ($urandom_range(2) != 0)) begin
                    pend[p] = 1'b1;
                    set_port(p, 1'($urandom_range(1)), 12'h040 + AW'($urandom_range(7)),
                             4'($urandom_range(15)), $urandom);
                end
            end
            cycle_drive(pend, e);
            n_chk++;
            if (gnt_o !== onehot(e)) begin
                n_fail++;
                $display("FAIL b2b_gnt: step %0d req=%b got %b required %b", i, pend, gnt_o, onehot(e));
            end
            if (e >= 0) begin
                n_chk++;
                if (mem_csn_o !== 1'b0 || mem_wen_o !== p_wen[e] || mem_addr_o !== p_addr[e] ||
                    mem_be_o !== p_be[e] || mem_wdata_o !== p_wdata[e]) begin
                    n_fail++;
                    $display("FAIL b2b_mem: step %0d csn=%b wen=%b addr=%h be=%h wdata=%h, port %0d", i, mem_csn_o, mem_wen_o, mem_addr_o, mem_be_o, mem_wdata_o, e);
                end
                pend[e] = 1'b0;
            end
            cycle_finish(e);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int e;
        set_port(2, 1'b1, 12'h050, 4'hF, 32'h0);
        cycle_drive(4'b0100, e);
        cycle_finish(e);
        set_port(1, 1'b1, 12'h010, 4'hF, 32'h0);
        cycle_drive(4'b0010, e);
        n_chk++;
        if (gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL midflight_gnt: got %b required 0010", gnt_o);
        end
        cycle_finish(e);
        // Access was launched on the last edge; reset now, before it returns.
        rst = 1'b1;
        req_i = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_rr = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, 12'h060 + AW'(p), 4'hF, 32'h0);
        cycle_drive('1, e);
        n_chk++;
        if (gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL midflight_first: got %b required 0001", gnt_o);
        end
        cycle_finish(e);
        drain();
    endtask

    task automatic test_pipeline();
        int e;
        do_reset();
        set_port(0, 1'b0, 12'h080, 4'hF, 32'h1111_1111);
        cycle_drive(4'b0001, e);
        cycle_finish(e);
        set_port(1, 1'b0, 12'h084, 4'hF, 32'h2222_2222);
        cycle_drive(4'b0010, e);
        cycle_finish(e);
        drain();
        set_port(0, 1'b1, 12'h080, 4'hF, 32'h0);
        set_port(1, 1'b1, 12'h084, 4'hF, 32'h0);
        cycle_drive(4'b0011, e);
        n_chk++;
        if (gnt_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL pipe_gnt0: got %b required 0001", gnt_o);
        end
        cycle_finish(e);
        cycle_drive(4'b0010, e);
        n_chk++;
        if (gnt_o !== 4'b0010) begin
            n_fail++;
            $display("FAIL pipe_gnt1: got %b required 0010", gnt_o);
        end
        cycle_finish(e);
        drain();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            bank[i] = '0;
            ref_mem[i] = '0;
        end
        rd1 = '0;
        rd2 = '0;
        for (int p = 0; p < NP; p++) rv_cnt[p] = 0;
        rst = 1'b1;
        req_i = '0;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, '0, 4'h0, 32'h0);

        test_reset();
        test_single_read();
        test_byte_enables();
        test_fairness();
        test_idle();
        test_back_to_back();
        test_reset_midflight();
        test_pipeline();

        n_chk++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d responses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
